// File: rtl/dual_scan_decoder_if.sv
// ----------------------------------------------------------------------------
// dual_scan_decoder_if
// Groups the control and strobe signals of dual_scan_decoder.
//   G_L   [CH-1:0]        per-channel active-low enable      (master -> slave)
//   SEL   [CH*SEL_W-1:0]  per-channel select, channel c at [c*SEL_W +: SEL_W]
//   SCAN                  0 = direct decode, 1 = scan mode    (master -> slave)
//   Y_L   [CH*N-1:0]      active-low strobes, channel c at [c*N +: N]
//   IDX   [SEL_W-1:0]     current scan index                  (slave -> master)
//   TICK                  one-cycle pulse per scan advance    (slave -> master)
// ----------------------------------------------------------------------------
interface dual_scan_decoder_if #(
    parameter int SEL_W = 2,
    parameter int CH    = 2
);
    localparam int N = 1 << SEL_W;

    logic [CH-1:0]       G_L;
    logic [CH*SEL_W-1:0] SEL;
    logic                SCAN;
    logic [CH*N-1:0]     Y_L;
    logic [SEL_W-1:0]    IDX;
    logic                TICK;

    modport master (
        output G_L, SEL, SCAN,
        input  Y_L, IDX, TICK
    );

    modport slave (
        input  G_L, SEL, SCAN,
        output Y_L, IDX, TICK
    );
endinterface

// File: rtl/dual_scan_decoder.sv
// ----------------------------------------------------------------------------
// dual_scan_decoder
// Registered multi-channel active-low line decoder with a scan mode that
// cycles every channel through all of its lines for multiplexed drive.
//
// Ports:
//   CLK      rising-edge clock for all state
//   RESET_L  asynchronous active-low reset (release must be synchronised
//            externally)
//   bus      dual_scan_decoder_if.slave: G_L, SEL, SCAN in; Y_L, IDX, TICK out
//
// Parameters: SEL_W (1..4), CH (1..8), SCAN_DIV (2..65535 clocks per step).
//
// Optional feature macro: DUAL_SCAN_DECODER_BLANK_EN
//   When defined, every enabled channel is blanked (all 1) on the TICK cycle
//   and the new index is driven from the following cycle, giving
//   break-before-make between adjacent lines. Direct mode is unaffected.
// ----------------------------------------------------------------------------
module dual_scan_decoder #(
    parameter int SEL_W    = 2,
    parameter int CH       = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic               CLK,
    input  logic               RESET_L,
    dual_scan_decoder_if.slave bus
);
    localparam int N  = 1 << SEL_W;
    localparam int PW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

`ifdef DUAL_SCAN_DECODER_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    generate
        if (SCAN_DIV < 2) begin : g_bad_scan_div
            $error("dual_scan_decoder: SCAN_DIV=%0d is below the minimum of 2", SCAN_DIV);
        end
    endgenerate

    typedef enum logic [0:0] {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_t;

    // Active-low one-of-N decode of a single channel select.
    function automatic logic [N-1:0] line_dec_f(input logic [SEL_W-1:0] sel);
        logic [N-1:0] one_hot;
        one_hot = {{(N-1){1'b0}}, 1'b1} << sel;
        return ~one_hot;
    endfunction

    mode_t             mode_r;
    logic [PW-1:0]     presc_r;
    logic [SEL_W-1:0]  idx_r;
    logic              tick_r;
    logic [CH*N-1:0]   y_l_r;

    mode_t             mode_nxt_s;
    logic [PW-1:0]     presc_nxt_s;
    logic [SEL_W-1:0]  idx_nxt_s;
    logic              tick_nxt_s;
    logic [CH*N-1:0]   y_l_nxt_s;

    // Next-state: mode tracking, prescaler/index sequencing and line decode.
    always_comb begin
        mode_nxt_s  = MODE_DIRECT;
        presc_nxt_s = presc_r;
        idx_nxt_s   = idx_r;
        tick_nxt_s  = 1'b0;
        y_l_nxt_s   = {(CH*N){1'b1}};

        if (bus.SCAN) begin
            mode_nxt_s = MODE_SCAN;
            case (mode_r)
                // Entering scan mode restarts the sequence at index 0 so the
                // first advance lands exactly SCAN_DIV cycles later.
                MODE_DIRECT: begin
                    presc_nxt_s = {PW{1'b0}};
                    idx_nxt_s   = {SEL_W{1'b0}};
                end
                MODE_SCAN: begin
                    if (presc_r == PRESC_LAST) begin
                        presc_nxt_s = {PW{1'b0}};
                        idx_nxt_s   = idx_r + SEL_W'(1);
                        tick_nxt_s  = 1'b1;
                    end else begin
                        presc_nxt_s = presc_r + PW'(1);
                    end
                end
                default: begin
                    presc_nxt_s = {PW{1'b0}};
                    idx_nxt_s   = {SEL_W{1'b0}};
                end
            endcase
        end else begin
            // Direct mode: IDX holds, prescaler parked at zero.
            mode_nxt_s  = MODE_DIRECT;
            presc_nxt_s = {PW{1'b0}};
        end

        // Lines are decoded from the next index so Y_L and IDX update together.
        for (int c = 0; c < CH; c++) begin
            if (bus.G_L[c]) begin
                y_l_nxt_s[c*N +: N] = {N{1'b1}};
            end else if (bus.SCAN) begin
                if (BLANK_EN && tick_nxt_s) begin
                    y_l_nxt_s[c*N +: N] = {N{1'b1}};
                end else begin
                    y_l_nxt_s[c*N +: N] = line_dec_f(idx_nxt_s);
                end
            end else begin
                y_l_nxt_s[c*N +: N] = line_dec_f(bus.SEL[c*SEL_W +: SEL_W]);
            end
        end
    end

    // State and output registers; reset forces every strobe inactive at once.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            mode_r  <= MODE_DIRECT;
            presc_r <= {PW{1'b0}};
            idx_r   <= {SEL_W{1'b0}};
            tick_r  <= 1'b0;
            y_l_r   <= {(CH*N){1'b1}};
        end else begin
            mode_r  <= mode_nxt_s;
            presc_r <= presc_nxt_s;
            idx_r   <= idx_nxt_s;
            tick_r  <= tick_nxt_s;
            y_l_r   <= y_l_nxt_s;
        end
    end

    assign bus.Y_L  = y_l_r;
    assign bus.IDX  = idx_r;
    assign bus.TICK = tick_r;

endmodule

// File: tb/tb_dual_scan_decoder.sv
// ----------------------------------------------------------------------------
// tb_dual_scan_decoder
// Directed self-checking bench for dual_scan_decoder with SEL_W=2, CH=2,
// SCAN_DIV=4. Outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_dual_scan_decoder;
    logic CLK;
    logic RESET_L;
    int   n_checks;
    int   n_errors;

`ifdef DUAL_SCAN_DECODER_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    // Direct-mode results for SEL = 0..15, SEL = {ch1_sel, ch0_sel}.
    logic [7:0] dir_tab [16] = '{
        8'hEE, 8'hED, 8'hEB, 8'hE7,
        8'hDE, 8'hDD, 8'hDB, 8'hD7,
        8'hBE, 8'hBD, 8'hBB, 8'hB7,
        8'h7E, 8'h7D, 8'h7B, 8'h77
    };

    dual_scan_decoder_if #(.SEL_W(2), .CH(2)) bus ();

    dual_scan_decoder #(.SEL_W(2), .CH(2), .SCAN_DIV(4)) dut (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .bus     (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Expected scan-mode outputs: k = edges since entry, g = G_L.
    task automatic chk_scan(input string tag, input int k, input logic [1:0] g);
        logic [1:0] e_idx;
        logic       e_tick;
        logic [3:0] line;
        logic [7:0] e_y;
        e_idx  = 2'((k / 4) % 4);
        e_tick = (k > 0) && ((k % 4) == 0);
        line   = ~(4'b0001 << e_idx);
        e_y    = {(g[1] ? 4'hF : line), (g[0] ? 4'hF : line)};
        if (BLANK && e_tick) begin
            e_y = 8'hFF;
        end
        chk($sformatf("%s_idx_k%0d", tag, k),  32'(bus.IDX),  32'(e_idx));
        chk($sformatf("%s_tick_k%0d", tag, k), 32'(bus.TICK), 32'(e_tick));
        chk($sformatf("%s_y_k%0d", tag, k),    32'(bus.Y_L),  32'(e_y));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.G_L  = 2'b11;
        bus.SEL  = 4'h0;
        bus.SCAN = 1'b0;
        RESET_L  = 1'b1;

        // 1. Reset state, then direct-mode sweep.
        #1 RESET_L = 1'b0;
        #1;
        chk("rst_y",    32'(bus.Y_L),  32'hFF);
        chk("rst_idx",  32'(bus.IDX),  32'h0);
        chk("rst_tick", 32'(bus.TICK), 32'h0);
        step();
        step();
        chk("rst_hold_y", 32'(bus.Y_L), 32'hFF);
        RESET_L  = 1'b1;
        bus.G_L  = 2'b00;
        bus.SEL  = 4'b1001;
        #1;
        chk("no_comb_path", 32'(bus.Y_L), 32'hFF);
        step();
        chk("dir_1001", 32'(bus.Y_L), 32'hBD);
        for (int s = 0; s < 16; s++) begin
            bus.SEL = 4'(s);
            step();
            chk($sformatf("dir_sweep_%0d", s), 32'(bus.Y_L), 32'(dir_tab[s]));
        end
        chk("dir_idx",  32'(bus.IDX),  32'h0);
        chk("dir_tick", 32'(bus.TICK), 32'h0);

        // 2. Direct-mode enable.
        bus.G_L = 2'b10;
        bus.SEL = 4'b0000;
        step();
        chk("en_ch1_off", 32'(bus.Y_L), 32'hFE);
        bus.G_L = 2'b11;
        step();
        chk("en_all_off", 32'(bus.Y_L), 32'hFF);

        // 3. Scan mode entry and 40 cycles of scanning; SEL must be ignored.
        bus.G_L  = 2'b00;
        bus.SEL  = 4'hB;
        bus.SCAN = 1'b1;
        #1;
        chk("scan_pre_entry", 32'(bus.Y_L), 32'hFF);
        step();
        chk_scan("scan", 0, 2'b00);
        for (int k = 1; k <= 40; k++) begin
            step();
            chk_scan("scan", k, 2'b00);
        end

        // 4. Channel 0 disabled while the index keeps advancing.
        bus.G_L = 2'b01;
        for (int k = 41; k <= 52; k++) begin
            step();
            chk_scan("scan_g01", k, 2'b01);
        end

        // 5. Reset asserted between edges at IDX=2.
        bus.G_L = 2'b00;
        for (int k = 53; k <= 57; k++) begin
            step();
            chk_scan("scan_pre_rst", k, 2'b00);
        end
        chk("mid_idx_is_2", 32'(bus.IDX), 32'h2);
        #2 RESET_L = 1'b0;
        #1;
        chk("midrst_y",    32'(bus.Y_L),  32'hFF);
        chk("midrst_idx",  32'(bus.IDX),  32'h0);
        chk("midrst_tick", 32'(bus.TICK), 32'h0);
        step();
        chk("midrst_hold_y", 32'(bus.Y_L), 32'hFF);
        RESET_L = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            step();
            chk_scan("restart", k, 2'b00);
        end

        // 6. SCAN dropped on a TICK cycle: direct decode on the next edge, IDX held.
        bus.SCAN = 1'b0;
        bus.SEL  = 4'b0110;
        step();
        chk("exit_y",    32'(bus.Y_L),  32'hDB);
        chk("exit_tick", 32'(bus.TICK), 32'h0);
        chk("exit_idx",  32'(bus.IDX),  32'h2);
        step();
        chk("exit_idx_hold", 32'(bus.IDX), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
